wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter XLEN, default 64: width of writeback data.
REQ-002 Parameter DEPTH, fixed value 2: number of writeback buffer entries; no other value is supported.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 i_valid  input  1: memory stage presents a retiring instruction this cycle.
REQ-006 i_rf_wr_en  input  1: instruction writes a destination register.
REQ-007 i_rf_wr_addr  input  5: destination register index.
REQ-008 i_rf_wr_data  input  XLEN: sign-extended load result or ALU result.
REQ-009 o_wb_ready  output  1: buffer can accept an entry; memory stage drives its o_mem_ready from this signal.
REQ-010 i_rf_grant  input  1: register-file write port is free this cycle.
REQ-011 o_rf_wen  output  1: register-file write strobe.
REQ-012 o_rf_waddr  output  5: register-file write index.
REQ-013 o_rf_wdata  output  XLEN: register-file write data.
REQ-014 i_fwd_addr  input  5: decode-stage source-operand query index.
REQ-015 o_fwd_hit  output  1: a buffered entry will write i_fwd_addr.
REQ-016 o_fwd_data  output  XLEN: data of the youngest matching buffered entry.
REQ-017 o_instret  output  64: retired-instruction count.

Function
REQ-018 Buffer is a 2-entry in-order FIFO with head pointer, tail pointer and 2-bit occupancy count (0..2).
REQ-019 o_wb_ready = (count < 2), decoded from registered state only; it has no combinational path from any input.
REQ-020 Push occurs when i_valid && o_wb_ready; the entry stores wr_en, addr and data; i_valid while o_wb_ready=0 is ignored and the upstream stage holds the entry.
REQ-021 Pop occurs when count > 0 && i_rf_grant; the head entry retires and the head pointer advances.
REQ-022 o_rf_wen = pop && head.wr_en && (head.addr != 0); o_rf_waddr and o_rf_wdata show the head entry whenever count > 0, else 0.
REQ-023 Entries with wr_en=0, or with addr=0, retire normally (they consume a pop) but never assert o_rf_wen.
REQ-024 Latency: an entry pushed in cycle N is poppable no earlier than cycle N+1; there is no same-cycle bypass from input to the register-file port.
REQ-025 Push and pop in the same cycle: count is unchanged and both pointers advance; with count=2 only the pop occurs, since ready is low.
REQ-026 Pointers are 1 bit and wrap modulo 2.
REQ-027 Forwarding: o_fwd_hit=1 when any valid entry has wr_en=1 and addr == i_fwd_addr != 0; when both entries match, the younger (tail-1) entry supplies o_fwd_data; with no hit, o_fwd_data=0.
REQ-028 Forwarding is combinational on i_fwd_addr and registered state, and ignores the current-cycle push.

Reset
REQ-029 While rst_n=0: count, pointers and entry valid state are 0, o_wb_ready=1, o_rf_wen=0, o_rf_waddr=0, o_rf_wdata=0, o_fwd_hit=0, o_fwd_data=0, o_instret=0.
REQ-030 Reset asserted mid-operation discards buffered entries with no register-file write; operation resumes on the first rising edge after deassertion.

Configuration
REQ-031 Macro WB_INSTRET_EN defined: o_instret increments by 1 on every pop, including non-writing entries, and wraps from 2^64-1 to 0.
REQ-032 Macro WB_INSTRET_EN undefined: no counter flops are built and o_instret is constant 0.

Verification
REQ-033 Single push with addr=5, data=0xDEAD and i_rf_grant=1 -> o_rf_wen=1, waddr=5, wdata=0xDEAD exactly one cycle later; o_instret=1 (macro on).
REQ-034 i_rf_grant=0 and three back-to-back valid pushes -> o_wb_ready=0 after the second push, third entry held; grant=1 -> writes retire in order 1,2,3.
REQ-035 Push with addr=0, data=0xFFFF -> entry pops, o_rf_wen stays 0; o_instret increments (macro on) or stays 0 (macro off).
REQ-036 Two buffered entries both addr=7 (data 0x11 then 0x22), i_fwd_addr=7 -> o_fwd_hit=1, o_fwd_data=0x22; i_fwd_addr=0 -> o_fwd_hit=0.
REQ-037 count=1 with push and pop in the same cycle -> count stays 1 and o_wb_ready stays 1; rst_n pulsed low with count=2 -> no o_rf_wen, all outputs 0, o_wb_ready=1.
REQ-038 Counter preloaded by force to 2^64-1, one pop -> o_instret=0.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: writeback buffer between the memory stage and the register file.
// Holds up to two retiring instructions in order, retires the head when the
// register-file write port is granted, and forwards buffered results to decode.
// Optional feature: define WB_INSTRET_EN to build the retired-instruction counter;
// without it o_instret is tied to zero and no counter flops exist.
module wb_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic            i_rf_wr_en,
  input  logic [4:0]      i_rf_wr_addr,
  input  logic [XLEN-1:0] i_rf_wr_data,
  output logic            o_wb_ready,
  input  logic            i_rf_grant,
  output logic            o_rf_wen,
  output logic [4:0]      o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata,
  input  logic [4:0]      i_fwd_addr,
  output logic            o_fwd_hit,
  output logic [XLEN-1:0] o_fwd_data,
  output logic [63:0]     o_instret
);

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 2;

  // Pointers are a single bit, so the design only works with two entries.
  logic             head_q;
  logic             tail_q;
  logic [CW-1:0]    count_q;

  logic [DEPTH-1:0] ent_vld_q;
  logic [DEPTH-1:0] ent_wen_q;
  logic [AW-1:0]    ent_addr_q [DEPTH];
  logic [XLEN-1:0]  ent_data_q [DEPTH];

  logic             push;
  logic             pop;
  logic             young_idx;
  logic             old_idx;
  logic             young_match;
  logic             old_match;

  // Ready comes only from registered occupancy, never from an input.
  assign o_wb_ready = (count_q != CW'(2));
  assign push       = i_valid && o_wb_ready;
  assign pop        = (count_q != CW'(0)) && i_rf_grant;

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= ~tail_q;
      if (pop)  head_q <= ~head_q;
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Entry storage: write at tail on push, invalidate head on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld_q <= '0;
      ent_wen_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      if (pop) ent_vld_q[head_q] <= 1'b0;
      if (push) begin
        ent_vld_q[tail_q]  <= 1'b1;
        ent_wen_q[tail_q]  <= i_rf_wr_en;
        ent_addr_q[tail_q] <= i_rf_wr_addr;
        ent_data_q[tail_q] <= i_rf_wr_data;
      end
    end
  end

  // Register-file port shows the head entry; x0 and non-writing entries never strobe.
  always_comb begin
    o_rf_wen   = 1'b0;
    o_rf_waddr = '0;
    o_rf_wdata = '0;
    if (count_q != CW'(0)) begin
      o_rf_waddr = ent_addr_q[head_q];
      o_rf_wdata = ent_data_q[head_q];
      o_rf_wen   = pop && ent_wen_q[head_q] && (ent_addr_q[head_q] != AW'(0));
    end
  end

  // Forwarding from buffered state only; the younger entry (tail-1) wins.
  always_comb begin
    young_idx   = ~tail_q;
    old_idx     = tail_q;
    young_match = ent_vld_q[young_idx] && ent_wen_q[young_idx] &&
                  (ent_addr_q[young_idx] == i_fwd_addr) && (i_fwd_addr != AW'(0));
    old_match   = ent_vld_q[old_idx] && ent_wen_q[old_idx] &&
                  (ent_addr_q[old_idx] == i_fwd_addr) && (i_fwd_addr != AW'(0));
    o_fwd_hit   = young_match || old_match;
    o_fwd_data  = '0;
    if (young_match) begin
      o_fwd_data = ent_data_q[young_idx];
    end else if (old_match) begin
      o_fwd_data = ent_data_q[old_idx];
    end
  end

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  // Count every retirement, writing or not; wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (pop) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign o_instret = instret_q;
`else
  assign o_instret = '0;
`endif

endmodule
